arb_rr4_ctrl: RTL and testbench
===============================

# arb_rr4_ctrl

Four-requester round-robin arbiter that shares one downstream resource (e.g. a 4-to-2 encoded select bus) between four requesters. Samples a 4-bit request vector, issues a registered one-hot grant plus its 2-bit encoded index, and holds the grant until the owner releases. An optional hold-timeout forces rotation so that one requester cannot starve the others.

## Interface
- `MAX_HOLD`, 8: maximum consecutive grant cycles before forced rotation. Used only with `ARB_TIMEOUT_EN`. Legal range 1..255.
- `clk` in 1: single clock, all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 4: request vector. Bit n is high while requester n wants or holds the resource.
- `gnt` out 4: one-hot grant, registered. Zero when idle.
- `gnt_idx` out 2: binary index of the set `gnt` bit (0..3). Holds its last value when idle.
- `gnt_vld` out 1: high exactly when `gnt` is non-zero.
- `preempt` out 1: one-cycle pulse on the edge a grant is removed by timeout. Tied 0 without the macro.

## Operation
- State machine: `IDLE` (no grant) and `BUSY` (one grant active).
- Rotation pointer `last[1:0]` holds the index of the most recent grant. Search order is `last+1`, `last+2`, `last+3`, `last` (mod 4).
- **IDLE:**
  - If `req` is non-zero, grant the first set bit in search order and go to `BUSY`.
  - Otherwise stay in `IDLE`.
- **BUSY, owner k:**
  - While `req[k]` is high (and no timeout), hold `gnt`, `gnt_idx` and `last` unchanged.
  - When `req[k]` is sampled low:
    - If any other request is set, grant the next one in search order starting at k+1, with no idle cycle. Stay in `BUSY`.
    - Otherwise clear `gnt` and go to `IDLE`.
  - `last` updates to the new index on every new grant.
- Only one `gnt` bit is ever set. `gnt_idx` always equals the encoding of `gnt` when `gnt_vld` is high.
- Requests that appear and drop while another requester owns the grant are not remembered. The arbiter has no request queueing.
- Reset values: `gnt`=0, `gnt_idx`=0, `gnt_vld`=0, `preempt`=0, `last`=3 (so the first arbitration after reset favours 0, then 1, 2, 3), hold counter 0, state `IDLE`.
- Reset asserted mid-grant clears everything immediately and asynchronously. The first grant after reset release again favours requester 0.

## Timing
- Latency from `req` rising (sampled at edge N) to `gnt` set: 1 cycle (visible after edge N).
- Release: `req[k]` low at edge N means `gnt[k]` is low after edge N. Any handoff grant appears on the same edge.
- Simultaneous requests: resolved by search order within one cycle.
- The owner dropping and re-raising in the same sampled cycle is treated as held.
- All outputs are registered. There is no combinational path from `req` to any output.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit hold counter resets to 0 on each new grant and increments every `BUSY` cycle.
  - When the counter reaches `MAX_HOLD` and another request is pending, the grant moves to the next requester in search order on that edge, and `preempt` pulses for 1 cycle.
  - If no other request is pending, the grant stays and the counter saturates at `MAX_HOLD`.
  - The preempted requester must keep its request high to be re-served in turn.
- **Undefined:**
  - There is no counter and no forced rotation.
  - The grant is held indefinitely while `req[k]` is high.
  - `preempt` is constant 0.

## Test plan
- Reset and basic grant:
  - Reset, then `req`=4'b0000 for 3 cycles -> `gnt`=0, `gnt_vld`=0.
  - Set `req`=4'b1111 -> 1 cycle later `gnt`=4'b0001, `gnt_idx`=0.
- Rotation:
  - Keep `req`=4'b1111 and drop each owner's bit for 1 cycle after 2 cycles of ownership.
  - Required grant order: 0→1→2→3→0, with no idle cycles between grants.
- Release to idle:
  - Only requester 2 requests; after it is granted, drop `req[2]` -> `gnt`=0 and `gnt_vld`=0 on the next edge.
  - Then raise `req[1]` -> 1 is granted, since pointer `last`=2 wraps through 3, 0, 1.
- Simultaneous and late requests:
  - With `last`=1, raise `req`=4'b1001 -> grant 3.
  - Raise `req[0]` mid-grant -> no change until requester 3 releases.
- Reset mid-grant:
  - Assert `rst_n` low while `gnt`=4'b0100 -> all outputs go to 0 immediately, without waiting for a clock edge.
  - After release, with `req`=4'b0110 -> grant 1.
- Timeout (`ARB_TIMEOUT_EN`, `MAX_HOLD`=4):
  - Hold `req`=4'b0011 constant -> `gnt` alternates 0 and 1 every 4 cycles, with `preempt` pulsing each switch.
  - With `req`=4'b0001 only -> grant held indefinitely and `preempt` stays 0.

Source files
------------

// File: rtl/arb_rr4_ctrl_if.sv
// arb_rr4_ctrl_if: request/grant bundle between four requesters and the
// round-robin arbiter. The arbiter side uses the slave modport; the
// requester/bench side uses the master modport.
interface arb_rr4_ctrl_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_vld,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_vld,
        output preempt
    );
endinterface

// File: rtl/arb_rr4_ctrl.sv
// arb_rr4_ctrl: four-requester round-robin arbiter with a registered one-hot
// grant, its encoded index and a valid flag. The grant is held until the
// owner drops its request, then handed to the next requester in rotation
// order without an idle cycle.
// Optional feature macro: ARB_TIMEOUT_EN -- adds an 8-bit hold counter that
// forces rotation after MAX_HOLD cycles when another request is pending and
// pulses preempt on that edge. Without it preempt is tied low.
module arb_rr4_ctrl #(
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    arb_rr4_ctrl_if.slave  bus
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t     r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_idx;
    logic       r_gnt_vld;
    logic [1:0] r_last;

    logic [2:0] w_pick_any;
    logic [2:0] w_pick_oth;
    logic       w_own_req;
    logic       w_timeout;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("arb_rr4_ctrl: MAX_HOLD must be within 1..255");
    end

    // Search order last+1, last+2, last+3, last; returns {found, index}.
    function automatic logic [2:0] f_pick(input logic [1:0] i_last, input logic [3:0] i_req);
        logic       found;
        logic [1:0] sel;
        logic [1:0] idx;
        found = 1'b0;
        sel   = i_last;
        for (int i = 1; i <= 4; i++) begin
            idx = i_last + 2'(i);
            if (!found && i_req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        return {found, sel};
    endfunction

    function automatic logic [3:0] f_onehot(input logic [1:0] i_idx);
        return 4'b0001 << i_idx;
    endfunction

    // In BUSY, r_last equals the owner index, so searching from r_last with
    // the owner masked out yields the next requester after the owner.
    assign w_pick_any = f_pick(r_last, bus.req);
    assign w_pick_oth = f_pick(r_last, bus.req & ~r_gnt);
    assign w_own_req  = bus.req[r_gnt_idx];

`ifdef ARB_TIMEOUT_EN
    localparam logic [8:0] LP_MAX = 9'(MAX_HOLD);

    logic [7:0] r_cnt;
    logic       r_preempt;
    logic [8:0] w_cnt_nxt;
    logic       w_hit;
    logic       w_new_grant;

    // The edge on which the counter would reach MAX_HOLD is the rotation edge,
    // so an owner keeps the grant for exactly MAX_HOLD cycles under contention.
    assign w_cnt_nxt   = {1'b0, r_cnt} + 9'd1;
    assign w_hit       = (w_cnt_nxt >= LP_MAX);
    assign w_timeout   = (r_state == ST_BUSY) && w_own_req && w_hit && w_pick_oth[2];
    assign w_new_grant = ((r_state == ST_IDLE) && w_pick_any[2]) ||
                         ((r_state == ST_BUSY) && (!w_own_req || w_timeout) && w_pick_oth[2]);

    // Hold counter: cleared on each new grant, saturating at MAX_HOLD; preempt pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 8'd0;
            r_preempt <= 1'b0;
        end else begin
            r_preempt <= w_timeout;
            if (w_new_grant) begin
                r_cnt <= 8'd0;
            end else if (r_state == ST_BUSY) begin
                r_cnt <= w_hit ? LP_MAX[7:0] : w_cnt_nxt[7:0];
            end
        end
    end

    assign bus.preempt = r_preempt;
`else
    assign w_timeout   = 1'b0;
    assign bus.preempt = 1'b0;
`endif

    // Arbitration FSM: grant from IDLE, hold/hand off/release in BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= 4'b0000;
            r_gnt_idx <= 2'd0;
            r_gnt_vld <= 1'b0;
            r_last    <= 2'd3;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any[2]) begin
                        r_gnt     <= f_onehot(w_pick_any[1:0]);
                        r_gnt_idx <= w_pick_any[1:0];
                        r_gnt_vld <= 1'b1;
                        r_last    <= w_pick_any[1:0];
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!w_own_req || w_timeout) begin
                        if (w_pick_oth[2]) begin
                            r_gnt     <= f_onehot(w_pick_oth[1:0]);
                            r_gnt_idx <= w_pick_oth[1:0];
                            r_gnt_vld <= 1'b1;
                            r_last    <= w_pick_oth[1:0];
                        end else begin
                            r_gnt     <= 4'b0000;
                            r_gnt_vld <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.gnt_idx = r_gnt_idx;
    assign bus.gnt_vld = r_gnt_vld;

endmodule

// File: tb/tb_arb_rr4_ctrl.sv
// tb_arb_rr4_ctrl: scoreboard bench for arb_rr4_ctrl. Each stimulus cycle
// pushes the expected registered outputs; a monitor pops and compares them
// one time unit after the following rising edge.
module tb_arb_rr4_ctrl;

`ifdef ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        logic       pre;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t sb_q[$];

    arb_rr4_ctrl_if u_if ();

    arb_rr4_ctrl #(
        .MAX_HOLD (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Drive one request vector and queue the outputs expected after the next edge.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] eg,
                        input logic [1:0] ei, input logic ep);
        exp_t e;
        @(negedge clk);
        u_if.req = r;
        e.tag = tag;
        e.gnt = eg;
        e.idx = ei;
        e.vld = (eg != 4'b0000);
        e.pre = ep;
        sb_q.push_back(e);
    endtask

    function automatic logic [3:0] oh(input logic [1:0] i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    // Monitor: compare registered outputs against the scoreboard head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.tag, ".gnt"}, 32'(u_if.gnt), 32'(e.gnt));
            chk({e.tag, ".idx"}, 32'(u_if.gnt_idx), 32'(e.idx));
            chk({e.tag, ".vld"}, 32'(u_if.gnt_vld), 32'(e.vld));
            chk({e.tag, ".pre"}, 32'(u_if.preempt), 32'(e.pre));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t, want completion earlier", $time);
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        logic [1:0] own;
        logic       pre;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        u_if.req  = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.gnt", 32'(u_if.gnt), 32'h0);
        chk("rst.idx", 32'(u_if.gnt_idx), 32'h0);
        chk("rst.vld", 32'(u_if.gnt_vld), 32'h0);
        chk("rst.pre", 32'(u_if.preempt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset, then all four request at once.
        for (int i = 0; i < 3; i++) step("idle", 4'b0000, 4'b0000, 2'd0, 1'b0);
        step("first", 4'b1111, 4'b0001, 2'd0, 1'b0);

        // Rotation 0->1->2->3->0 with back-to-back handoffs.
        step("rot0h", 4'b1111, 4'b0001, 2'd0, 1'b0);
        step("rot1",  4'b1110, 4'b0010, 2'd1, 1'b0);
        step("rot1h", 4'b1111, 4'b0010, 2'd1, 1'b0);
        step("rot2",  4'b1101, 4'b0100, 2'd2, 1'b0);
        step("rot2h", 4'b1111, 4'b0100, 2'd2, 1'b0);
        step("rot3",  4'b1011, 4'b1000, 2'd3, 1'b0);
        step("rot3h", 4'b1111, 4'b1000, 2'd3, 1'b0);
        step("rot0",  4'b0111, 4'b0001, 2'd0, 1'b0);

        // Release to idle; index holds its last value.
        step("rel0",  4'b0000, 4'b0000, 2'd0, 1'b0);
        step("g2",    4'b0100, 4'b0100, 2'd2, 1'b0);
        step("g2h",   4'b0100, 4'b0100, 2'd2, 1'b0);
        step("rel2",  4'b0000, 4'b0000, 2'd2, 1'b0);
        step("wrap1", 4'b0010, 4'b0010, 2'd1, 1'b0);
        step("rel1",  4'b0000, 4'b0000, 2'd1, 1'b0);

        // Simultaneous 0 and 3 with last=1 -> 3; late request 0 waits.
        step("sim3",  4'b1001, 4'b1000, 2'd3, 1'b0);
        step("hold3", 4'b1000, 4'b1000, 2'd3, 1'b0);
        step("late0", 4'b1001, 4'b1000, 2'd3, 1'b0);
        step("late0b",4'b1001, 4'b1000, 2'd3, 1'b0);
        step("hand0", 4'b0001, 4'b0001, 2'd0, 1'b0);

        // A request that comes and goes during another's grant is forgotten.
        step("blip",  4'b0101, 4'b0001, 2'd0, 1'b0);
        step("blipx", 4'b0001, 4'b0001, 2'd0, 1'b0);
        step("forget",4'b0000, 4'b0000, 2'd0, 1'b0);

        // Asynchronous reset in the middle of a grant to requester 2.
        step("pre_rst", 4'b0100, 4'b0100, 2'd2, 1'b0);
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        u_if.req = 4'b0000;
        #1;
        chk("arst.gnt", 32'(u_if.gnt), 32'h0);
        chk("arst.idx", 32'(u_if.gnt_idx), 32'h0);
        chk("arst.vld", 32'(u_if.gnt_vld), 32'h0);
        chk("arst.pre", 32'(u_if.preempt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst",  4'b0110, 4'b0010, 2'd1, 1'b0);
        step("post_rsth", 4'b0110, 4'b0010, 2'd1, 1'b0);
        step("post_rel",  4'b0000, 4'b0000, 2'd1, 1'b0);

        // Constant contention between 0 and 1 (last=1, so 0 wins first).
        for (int i = 1; i <= 12; i++) begin
            own = TMO ? 2'(((i - 1) / 4) % 2) : 2'd0;
            pre = TMO && (i > 1) && (((i - 1) % 4) == 0);
            step($sformatf("cont%0d", i), 4'b0011, oh(own), own, pre);
        end
        step("cont_rel", 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Lone requester is never preempted.
        for (int i = 1; i <= 12; i++) begin
            step($sformatf("solo%0d", i), 4'b0001, 4'b0001, 2'd0, 1'b0);
        end
        step("solo_rel", 4'b0000, 4'b0000, 2'd0, 1'b0);

        @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
